// File: rtl/mem_copy_dma.sv
// mem_copy_dma: block-copy engine that borrows the memory port from the processor.
// Idle/done pass the cpu port through; RD/WR alternate one read and one write per word.
module mem_copy_dma #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   input  logic              cpu_wr_en,
   output logic [DATA_W-1:0] cpu_q,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wr_en,
   input  logic [DATA_W-1:0] mem_q
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   state_t            state, state_next;
   logic [ADDR_W-1:0] rd_ptr, wr_ptr;
   logic [ADDR_W:0]   remaining;
   logic [DATA_W-1:0] data_buf;
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         remaining <= '0;
         data_buf  <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start && len != '0) begin
            rd_ptr    <= src;
            wr_ptr    <= dst;
            remaining <= len;
         end
         if (state == RD) begin
            data_buf <= mem_q;
            rd_ptr   <= rd_ptr + ADDR_W'(1);
         end
         if (state == WR) begin
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
         end
      end
   end
   // The WR-state write is driven from registered state only, so a write already in
   // flight still lands on the edge that applies reset; passthrough writes are gated.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      mem_addr   = cpu_addr;
      mem_data   = cpu_data;
      mem_wr_en  = cpu_wr_en & Resetn;
      case (state)
         IDLE: state_next = start ? ((len == '0) ? DONE : RD) : IDLE;
         RD: begin
            state_next = WR;
            busy       = 1'b1;
            mem_addr   = rd_ptr;
            mem_wr_en  = 1'b0;
         end
         WR: begin
            state_next = (remaining == (ADDR_W+1)'(1)) ? DONE : RD;
            busy       = 1'b1;
            mem_addr   = wr_ptr;
            mem_data   = data_buf;
            mem_wr_en  = 1'b1;
         end
         default: begin
            state_next = IDLE;
            done       = 1'b1;
         end
      endcase
   end
   assign cpu_q = mem_q;
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: directed bench for mem_copy_dma with a behavioural 32x16 memory.
module tb_mem_copy_dma;
   logic        Clock = 1'b0;
   logic        Resetn, start, cpu_wr_en;
   logic [4:0]  src, dst, cpu_addr;
   logic [5:0]  len;
   logic [15:0] cpu_data;
   logic        busy, done, mem_wr_en;
   logic [15:0] cpu_q, mem_data, mem_q;
   logic [4:0]  mem_addr;
   logic [15:0] mem [32];
   int          checks = 0;
   int          failures = 0;
   int          cyc, wrs, dones;

   mem_copy_dma dut (
      .Clock(Clock), .Resetn(Resetn), .start(start), .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .cpu_wr_en(cpu_wr_en), .cpu_q(cpu_q), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_wr_en(mem_wr_en), .mem_q(mem_q)
   );

   always #5 Clock = ~Clock;
   assign mem_q = mem[mem_addr];
   always @(posedge Clock) if (mem_wr_en) mem[mem_addr] <= mem_data;

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts a copy, then counts cycles after the start edge until done (bounded).
   task automatic run_copy(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l);
      src = s; dst = d; len = l; start = 1'b1;
      tick;
      start = 1'b0;
      cyc = 1;
      wrs = 0;
      while (!done && cyc < 200) begin
         if (mem_wr_en) wrs++;
         tick;
         cyc++;
      end
      tick;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'h0;
      Resetn = 1'b0; start = 1'b0; cpu_wr_en = 1'b1; cpu_addr = 5'd0; cpu_data = 16'h0;
      src = '0; dst = '0; len = '0;
      tick;
      tick;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_gated", mem_wr_en, 0);
      cpu_wr_en = 1'b0;
      Resetn = 1'b1;
      tick;

      cpu_addr = 5'd3; cpu_data = 16'h1234; cpu_wr_en = 1'b1;
      #1;
      check("pass_wr_en", mem_wr_en, 1);
      check("pass_addr", mem_addr, 3);
      tick;
      cpu_wr_en = 1'b0;
      #1;
      check("pass_q", cpu_q, 16'h1234);
      check("pass_busy", busy, 0);

      mem[0] = 16'hf000; mem[1] = 16'h001a; mem[2] = 16'hf100; mem[3] = 16'h000f;
      src = 5'd0; dst = 5'h10; len = 6'd4; start = 1'b1;
      #1;
      check("no_comb_start", busy, 0);
      tick;
      for (int c = 1; c <= 8; c++) begin
         if (c == 2) begin
            start = 1'b1; src = 5'd20; dst = 5'd25; len = 6'd2;
            cpu_wr_en = 1'b1; cpu_addr = 5'd0; cpu_data = 16'hdead;
            #1;
         end
         if (c == 8) begin
            start = 1'b0; cpu_wr_en = 1'b0;
            #1;
         end
         check($sformatf("basic_busy_c%0d", c), busy, 1);
         check($sformatf("basic_done_c%0d", c), done, 0);
         check($sformatf("basic_we_c%0d", c), mem_wr_en, (c % 2 == 0) ? 1 : 0);
         tick;
      end
      check("basic_done9", done, 1);
      check("basic_busy9", busy, 0);
      tick;
      check("basic_idle_done", done, 0);
      check("basic_idle_busy", busy, 0);
      check("basic_d0", mem[16], 16'hf000);
      check("basic_d1", mem[17], 16'h001a);
      check("basic_d2", mem[18], 16'hf100);
      check("basic_d3", mem[19], 16'h000f);
      check("basic_s0", mem[0], 16'hf000);
      check("basic_s3", mem[3], 16'h000f);
      check("ignored_start", mem[25], 16'h0);

      mem[30] = 16'h3030; mem[31] = 16'h3131;
      run_copy(5'd30, 5'd2, 6'd3);
      check("wrap_cycles", cyc, 7);
      check("wrap_m2", mem[2], 16'h3030);
      check("wrap_m3", mem[3], 16'h3131);
      check("wrap_m4", mem[4], 16'hf000);

      run_copy(5'd7, 5'd9, 6'd0);
      check("len0_cycles", cyc, 1);
      check("len0_writes", wrs, 0);

      mem[5] = 16'habcd;
      run_copy(5'd5, 5'd6, 6'd3);
      check("ovl_cycles", cyc, 7);
      check("ovl_m6", mem[6], 16'habcd);
      check("ovl_m7", mem[7], 16'habcd);
      check("ovl_m8", mem[8], 16'habcd);

      mem[15] = 16'h0f0f;
      run_copy(5'd0, 5'd16, 6'd32);
      check("len32_cycles", cyc, 65);
      check("len32_writes", wrs, 32);
      check("len32_m31", mem[31], 16'h0f0f);
      check("len32_m15", mem[15], 16'h0f0f);

      mem[10] = 16'h00a0; mem[11] = 16'h00a1; mem[12] = 16'h00a2; mem[13] = 16'h00a3;
      mem[20] = 16'h5555; mem[21] = 16'h5555; mem[22] = 16'h5555; mem[23] = 16'h5555;
      src = 5'd10; dst = 5'd20; len = 6'd4; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      tick;
      check("rstmid_we", mem_wr_en, 1);
      Resetn = 1'b0;
      tick;
      check("rstmid_busy", busy, 0);
      check("rstmid_done", done, 0);
      check("rstmid_we_low", mem_wr_en, 0);
      Resetn = 1'b1;
      dones = 0;
      for (int c = 0; c < 8; c++) begin
         if (done) dones++;
         tick;
      end
      check("rstmid_no_done", dones, 0);
      check("rstmid_m20", mem[20], 16'h00a0);
      check("rstmid_m21", mem[21], 16'h00a1);
      check("rstmid_m22", mem[22], 16'h5555);
      check("rstmid_m23", mem[23], 16'h5555);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
